// File: rtl/psm_vreg_responder.sv
// psm_vreg_responder: turns the PSM's vreq/vlevel request into a slewed VID code and returns vack
// once the regulator output has settled and the PMIC reports power-good.
module psm_vreg_responder #(
  parameter int VID_W = 8,
  parameter int VID_L0 = 40,
  parameter int VID_L1 = 60,
  parameter int VID_L2 = 80,
  parameter int VID_L3 = 100,
  parameter int VID_L4 = 120,
  parameter int STEP_VID = 4,
  parameter int SLEW_US = 1,
  parameter int SETTLE_US = 3,
  parameter int PGOOD_TIMEOUT_US = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick_us_i,
  input  logic             vreq_i,
  input  logic [2:0]       vlevel_i,
  output logic             vack_o,
  output logic [VID_W-1:0] vcode_o,
  output logic             vcode_upd_o,
  input  logic             pgood_i,
  output logic             busy_o,
  output logic             err_o,
  input  logic             clr_err_i,
  output logic [2:0]       cur_level_o
);
  localparam int DW = VID_W + 1;
  localparam int SW = $clog2(SLEW_US + 1);
  localparam int CW = $clog2(SETTLE_US + PGOOD_TIMEOUT_US + 1);
  typedef enum logic [2:0] {IDLE, RAMP, SETTLE, ACK, ERR} state_t;
  state_t state;
  logic [2:0] lvl;
  logic [VID_W-1:0] tgt, step, next_code;
  logic [DW-1:0] diff;
  logic up, at_tgt, lvl_chg, slew_due;
  logic [SW-1:0] slew_cnt;
  logic [CW-1:0] settle_cnt, settle_nxt;
  always_comb begin
    lvl = (vlevel_i > 3'd4) ? 3'd4 : vlevel_i;
    tgt = (lvl == 3'd0) ? VID_W'(VID_L0) :
          (lvl == 3'd1) ? VID_W'(VID_L1) :
          (lvl == 3'd2) ? VID_W'(VID_L2) :
          (lvl == 3'd3) ? VID_W'(VID_L3) : VID_W'(VID_L4);
    up = tgt > vcode_o;
    diff = up ? {1'b0, tgt} - {1'b0, vcode_o} : {1'b0, vcode_o} - {1'b0, tgt};
    // the step is clipped to the remaining distance, so the code can never overshoot or wrap
    step = (diff > DW'(STEP_VID)) ? VID_W'(STEP_VID) : diff[VID_W-1:0];
    next_code = up ? vcode_o + step : vcode_o - step;
    at_tgt = tgt == vcode_o;
    lvl_chg = lvl != cur_level_o;
    slew_due = tick_us_i && (slew_cnt == SW'(SLEW_US - 1));
    settle_nxt = settle_cnt + CW'(tick_us_i);
  end
  assign busy_o = (state == RAMP) || (state == SETTLE);
  assign vack_o = (state == ACK) && vreq_i && at_tgt && pgood_i;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      vcode_o <= VID_W'(VID_L0);
      vcode_upd_o <= 1'b0;
      err_o <= 1'b0;
      cur_level_o <= 3'd0;
      slew_cnt <= '0;
      settle_cnt <= '0;
    end else begin
      vcode_upd_o <= 1'b0;
      case (state)
        IDLE: if (vreq_i) begin
          cur_level_o <= lvl;
          slew_cnt <= '0;
          settle_cnt <= '0;
          state <= at_tgt ? SETTLE : RAMP;
        end
        RAMP: if (!vreq_i) state <= IDLE;
        else begin
          cur_level_o <= lvl;
          settle_cnt <= '0;
          if (at_tgt) state <= SETTLE;
          else if (tick_us_i) begin
            slew_cnt <= slew_due ? '0 : slew_cnt + 1'b1;
            if (slew_due) begin
              vcode_o <= next_code;
              vcode_upd_o <= 1'b1;
              if (next_code == tgt) state <= SETTLE;
            end
          end
        end
        SETTLE: if (!vreq_i) state <= IDLE;
        else if (lvl_chg) begin
          cur_level_o <= lvl;
          settle_cnt <= '0;
          state <= at_tgt ? SETTLE : RAMP;
        end else if (settle_nxt >= CW'(SETTLE_US) && pgood_i) state <= ACK;
        else if (tick_us_i && settle_nxt >= CW'(SETTLE_US + PGOOD_TIMEOUT_US)) begin
          state <= ERR;
          err_o <= 1'b1;
        end else settle_cnt <= settle_nxt;
        ACK: if (!vreq_i) state <= IDLE;
        else if (lvl_chg) begin
          cur_level_o <= lvl;
          settle_cnt <= '0;
          state <= at_tgt ? SETTLE : RAMP;
        end else if (!pgood_i) begin
          // power-good loss skips the settle wait and only opens the timeout window
          state <= SETTLE;
          settle_cnt <= CW'(SETTLE_US);
        end
        ERR: if (clr_err_i) begin
          err_o <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_psm_vreg_responder.sv
// tb_psm_vreg_responder: vector table, directed corner sequences and random traffic checked
// against a cycle-level behavioural model of the voltage responder.
module tb_psm_vreg_responder;
  localparam int STEP = 4, SLEW = 1, SETTLE = 3, TMO = 20;
  localparam int S_IDLE = 0, S_RAMP = 1, S_SETTLE = 2, S_ACK = 3, S_ERR = 4;
  logic clk = 0, rst_n = 1, tick = 0, vreq = 0, pgood = 0, clr_err = 0;
  logic [2:0] vlevel = 0;
  logic vack, upd, busy, err, d2_vack, d2_upd, d2_busy, d2_err;
  logic [7:0] code, d2_code;
  logic [2:0] cur, d2_cur;
  int n_cmp = 0, n_bad = 0, upd_cnt = 0, d2_upd_cnt = 0, d2_max = 0;
  int vids[5] = '{40, 60, 80, 100, 120};
  int m_ph, m_code, m_lvl, m_sl, m_st;
  bit m_err, m_upd;
  typedef struct {
    logic vreq;
    logic [2:0] lvl;
    logic pg;
    logic tk;
    logic e_vack;
    logic e_busy;
    logic [7:0] e_code;
  } vec_t;
  vec_t tbl[8];

  always #5 clk = ~clk;

  psm_vreg_responder dut (
    .clk(clk), .rst_n(rst_n), .tick_us_i(tick), .vreq_i(vreq), .vlevel_i(vlevel),
    .vack_o(vack), .vcode_o(code), .vcode_upd_o(upd), .pgood_i(pgood), .busy_o(busy),
    .err_o(err), .clr_err_i(clr_err), .cur_level_o(cur)
  );
  psm_vreg_responder #(.VID_L1(80), .VID_L2(82)) dut2 (
    .clk(clk), .rst_n(rst_n), .tick_us_i(tick), .vreq_i(vreq), .vlevel_i(vlevel),
    .vack_o(d2_vack), .vcode_o(d2_code), .vcode_upd_o(d2_upd), .pgood_i(pgood), .busy_o(d2_busy),
    .err_o(d2_err), .clr_err_i(clr_err), .cur_level_o(d2_cur)
  );

  function automatic vec_t mk(bit v, int l, bit p, bit t, bit ev, bit eb, int ec);
    vec_t r;
    r.vreq = v; r.lvl = 3'(l); r.pg = p; r.tk = t; r.e_vack = ev; r.e_busy = eb; r.e_code = 8'(ec);
    return r;
  endfunction

  function automatic int clampl(int l);
    return (l > 4) ? 4 : l;
  endfunction

  task automatic chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    int l;
    l = clampl(int'(vlevel));
    chk("vcode", int'(code), m_code);
    chk("vcode_upd", int'(upd), int'(m_upd));
    chk("busy", int'(busy), int'(m_ph == S_RAMP || m_ph == S_SETTLE));
    chk("err", int'(err), int'(m_err));
    chk("cur_level", int'(cur), m_lvl);
    chk("vack", int'(vack), int'(m_ph == S_ACK && vreq && vids[l] == m_code && pgood));
    upd_cnt += int'(upd);
    d2_upd_cnt += int'(d2_upd);
    if (int'(d2_code) > d2_max) d2_max = int'(d2_code);
  endtask

  // next-state of the reference model, evaluated with the inputs seen at the clock edge
  task automatic model_update();
    int l, t, d, n;
    l = clampl(int'(vlevel));
    t = vids[l];
    m_upd = 0;
    case (m_ph)
      S_IDLE: if (vreq) begin
        m_lvl = l; m_sl = 0; m_st = 0;
        m_ph = (m_code == t) ? S_SETTLE : S_RAMP;
      end
      S_RAMP: if (!vreq) m_ph = S_IDLE;
      else begin
        m_lvl = l; m_st = 0;
        if (m_code == t) m_ph = S_SETTLE;
        else if (tick) begin
          m_sl++;
          if (m_sl >= SLEW) begin
            m_sl = 0;
            d = t - m_code;
            if (d > STEP) d = STEP;
            if (d < -STEP) d = -STEP;
            m_code += d;
            m_upd = 1;
            if (m_code == t) m_ph = S_SETTLE;
          end
        end
      end
      S_SETTLE: if (!vreq) m_ph = S_IDLE;
      else if (l != m_lvl) begin
        m_lvl = l; m_st = 0;
        m_ph = (m_code == t) ? S_SETTLE : S_RAMP;
      end else begin
        n = m_st + int'(tick);
        if (n >= SETTLE && pgood) m_ph = S_ACK;
        else if (tick && n >= SETTLE + TMO) begin m_ph = S_ERR; m_err = 1; end
        else m_st = n;
      end
      S_ACK: if (!vreq) m_ph = S_IDLE;
      else if (l != m_lvl) begin
        m_lvl = l; m_st = 0;
        m_ph = (m_code == t) ? S_SETTLE : S_RAMP;
      end else if (!pgood) begin m_ph = S_SETTLE; m_st = SETTLE; end
      default: if (clr_err) begin m_err = 0; m_ph = S_IDLE; end
    endcase
  endtask

  task automatic cyc();
    #1;
    check_model();
    @(posedge clk);
    model_update();
    @(negedge clk);
    tick = 0;
    clr_err = 0;
  endtask

  task automatic tk(int n, int gap);
    for (int i = 0; i < n; i++) begin
      repeat (gap - 1) cyc();
      tick = 1;
      cyc();
    end
  endtask

  task automatic do_reset();
    rst_n = 0;
    vreq = 0; tick = 0; clr_err = 0; vlevel = 0;
    m_ph = S_IDLE; m_code = 40; m_lvl = 0; m_sl = 0; m_st = 0; m_err = 0; m_upd = 0;
    #1;
    chk("rst_vcode", int'(code), 40);
    chk("rst_upd", int'(upd), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_cur", int'(cur), 0);
    chk("rst_vack", int'(vack), 0);
    chk("rst_d2_vcode", int'(d2_code), 40);
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    tbl[0] = mk(1, 0, 1, 0, 0, 0, 40);
    tbl[1] = mk(1, 0, 1, 1, 0, 1, 40);
    tbl[2] = mk(1, 0, 1, 0, 0, 1, 40);
    tbl[3] = mk(1, 0, 1, 1, 0, 1, 40);
    tbl[4] = mk(1, 0, 1, 1, 0, 1, 40);
    tbl[5] = mk(1, 0, 1, 0, 1, 0, 40);
    tbl[6] = mk(0, 0, 1, 0, 0, 0, 40);
    tbl[7] = mk(0, 0, 1, 0, 0, 0, 40);
    #1;
    pgood = 1;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      vreq = tbl[i].vreq; vlevel = tbl[i].lvl; pgood = tbl[i].pg; tick = tbl[i].tk;
      #1;
      chk($sformatf("tbl%0d_vack", i), int'(vack), int'(tbl[i].e_vack));
      chk($sformatf("tbl%0d_busy", i), int'(busy), int'(tbl[i].e_busy));
      chk($sformatf("tbl%0d_vcode", i), int'(code), int'(tbl[i].e_code));
      cyc();
    end
    // level 0 with sparse ticks, then ramp 40 -> 80
    vreq = 1; vlevel = 0; pgood = 1;
    cyc();
    tk(3, 10);
    #1 chk("B_ack_lvl0", int'(vack), 1);
    vlevel = 2;
    #1 chk("B_vack_drop", int'(vack), 0);
    upd_cnt = 0;
    cyc();
    tk(10, 4);
    cyc();
    #1;
    chk("B_vcode80", int'(code), 80);
    chk("B_upd_cnt", upd_cnt, 10);
    chk("B_cur2", int'(cur), 2);
    tk(3, 4);
    #1 chk("B_ack_lvl2", int'(vack), 1);
    // retarget mid-ramp onto the current code, then clamp level 7
    vreq = 0;
    cyc();
    do_reset();
    vreq = 1; vlevel = 4;
    cyc();
    tk(5, 3);
    #1 chk("C_vcode60", int'(code), 60);
    vlevel = 1;
    cyc();
    #1;
    chk("C_hold60", int'(code), 60);
    chk("C_settling", int'(busy), 1);
    chk("C_cur1", int'(cur), 1);
    upd_cnt = 0;
    tk(3, 3);
    #1;
    chk("C_ack", int'(vack), 1);
    chk("C_no_upd", upd_cnt, 0);
    vlevel = 7;
    cyc();
    tk(15, 2);
    cyc();
    #1;
    chk("C_vcode120", int'(code), 120);
    chk("C_cur4", int'(cur), 4);
    // partial final step on the overridden instance (80 -> 82)
    do_reset();
    vreq = 1; vlevel = 1; pgood = 1;
    cyc();
    tk(15, 2);
    cyc();
    #1;
    chk("D_d2_ack", int'(d2_vack), 1);
    chk("D_d2_vcode80", int'(d2_code), 80);
    vlevel = 2; d2_upd_cnt = 0; d2_max = 0;
    cyc();
    tk(1, 2);
    cyc();
    #1;
    chk("D_d2_vcode82", int'(d2_code), 82);
    chk("D_d2_one_step", d2_upd_cnt, 1);
    tk(8, 2);
    cyc();
    #1;
    chk("D_d2_no_overshoot", d2_max, 82);
    chk("D_d2_upd_total", d2_upd_cnt, 1);
    chk("D_d2_ack82", int'(d2_vack), 1);
    // pgood never arrives: timeout, frozen error state, clear and retry
    do_reset();
    pgood = 0; vreq = 1; vlevel = 0;
    cyc();
    tk(22, 2);
    #1 chk("E_no_err_yet", int'(err), 0);
    tk(1, 2);
    #1;
    chk("E_err", int'(err), 1);
    chk("E_err_vack", int'(vack), 0);
    chk("E_err_busy", int'(busy), 0);
    vreq = 0;
    cyc();
    vreq = 1; vlevel = 3; pgood = 1;
    cyc();
    tk(3, 2);
    #1;
    chk("E_err_hold", int'(err), 1);
    chk("E_frozen_vcode", int'(code), 40);
    chk("E_ignored_cur", int'(cur), 0);
    clr_err = 1;
    cyc();
    #1;
    chk("E_cleared", int'(err), 0);
    chk("E_idle_busy", int'(busy), 0);
    tk(20, 2);
    cyc();
    #1;
    chk("E_retry_ack", int'(vack), 1);
    chk("E_retry_vcode", int'(code), 100);
    // pgood glitch while acknowledged
    pgood = 0;
    #1 chk("F_vack_drop", int'(vack), 0);
    cyc();
    tk(5, 2);
    #1;
    chk("F_window_busy", int'(busy), 1);
    chk("F_window_err", int'(err), 0);
    pgood = 1;
    cyc();
    #1 chk("F_vack_back", int'(vack), 1);
    // clear pulse coinciding with the timeout tick must lose
    do_reset();
    pgood = 0; vreq = 1;
    cyc();
    tk(22, 2);
    cyc();
    tick = 1; clr_err = 1;
    cyc();
    #1 chk("G_err_wins", int'(err), 1);
    clr_err = 1;
    cyc();
    #1 chk("G_clr", int'(err), 0);
    // asynchronous reset in the middle of a ramp
    do_reset();
    vreq = 1; vlevel = 4; pgood = 1;
    cyc();
    tk(8, 2);
    cyc();
    #1 chk("H_vcode72", int'(code), 72);
    do_reset();
    // random traffic against the model
    pgood = 1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 99) < 3) vreq = ~vreq;
      if ($urandom_range(0, 99) < 3) vlevel = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 99) < 2) pgood = ~pgood;
      tick = ($urandom_range(0, 2) == 0);
      clr_err = ($urandom_range(0, 99) < 2);
      cyc();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
